// File: rtl/rst_release_seq_if.sv
// Reset-sequencing handshake between the controlling domain and a peer domain.
// master = sequencer (drives peer reset and status), slave = peer/system side.
interface rst_release_seq_if;
  logic sw_rst_req;
  logic peer_rdy;
  logic peer_rst_n;
  logic rst_done;
  logic busy;
  logic timeout_err;

  modport master (
    input  sw_rst_req,
    input  peer_rdy,
    output peer_rst_n,
    output rst_done,
    output busy,
    output timeout_err
  );

  modport slave (
    output sw_rst_req,
    output peer_rdy,
    input  peer_rst_n,
    input  rst_done,
    input  busy,
    input  timeout_err
  );
endinterface

// File: rtl/rst_release_seq.sv
// Sequences reset of a peer clock domain: hold, release, confirm via synchronized peer_rdy, with timeout.
// Latency: peer_rst_n rises HOLD_CYCLES edges after reset; rst_done <= SYNC_STAGES+1 edges after peer_rdy. No backpressure.
module rst_release_seq #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk_sync,
  input  logic               async_rst,
  rst_release_seq_if.master  bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_WAIT_LOW = 3'd1,
    S_RELEASE  = 3'd2,
    S_RUN      = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic                peer_rdy_s;
  logic                peer_rst_n_q, rst_done_q, busy_q, timeout_err_q;

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] rdy_sync;

  always_ff @(posedge clk_sync or negedge async_rst) begin
    if (!async_rst) rdy_sync <= '0;
    else            rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], bus.peer_rdy};
  end

  assign peer_rdy_s = rdy_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_sync or negedge async_rst) begin
    if (!async_rst) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      to_cnt   <= to_nxt;
    end
  end

  // Counters default to zero so any state change clears them; they never wrap.
  always_comb begin
    state_nxt = state;
    hold_nxt  = '0;
    to_nxt    = '0;
    case (state)
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nxt = peer_rdy_s ? S_WAIT_LOW : S_RELEASE;
        else                       hold_nxt  = hold_cnt + 1'b1;
      end
      S_WAIT_LOW: begin
        if (!peer_rdy_s)            state_nxt = S_RELEASE;
        else if (to_cnt == TO_LAST) state_nxt = S_ERR;
        else                        to_nxt    = to_cnt + 1'b1;
      end
      S_RELEASE: begin
        if (peer_rdy_s)             state_nxt = S_RUN;
        else if (to_cnt == TO_LAST) state_nxt = S_ERR;
        else                        to_nxt    = to_cnt + 1'b1;
      end
      S_RUN:   state_nxt = S_RUN;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_HOLD;
    endcase
    if (bus.sw_rst_req) begin
      state_nxt = S_HOLD;
      hold_nxt  = '0;
      to_nxt    = '0;
    end
  end

  // Outputs decoded from next state so they change on the same edge as the state.
  always_ff @(posedge clk_sync or negedge async_rst) begin
    if (!async_rst) begin
      peer_rst_n_q  <= 1'b0;
      rst_done_q    <= 1'b0;
      busy_q        <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      peer_rst_n_q  <= (state_nxt == S_RELEASE) || (state_nxt == S_RUN);
      rst_done_q    <= (state_nxt == S_RUN);
      busy_q        <= (state_nxt == S_HOLD) || (state_nxt == S_WAIT_LOW) ||
                       (state_nxt == S_RELEASE);
      timeout_err_q <= (state_nxt == S_ERR);
    end
  end

  assign bus.peer_rst_n  = peer_rst_n_q;
  assign bus.rst_done    = rst_done_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Directed bench for rst_release_seq: expected output transitions are queued and matched
// against the edge number and output vector at which the DUT actually changes.
module tb_rst_release_seq;
  logic clk_sync  = 1'b0;
  logic async_rst = 1'b0;

  rst_release_seq_if bus();

  rst_release_seq #(
    .HOLD_CYCLES    (16),
    .TIMEOUT_CYCLES (1024),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_sync  (clk_sync),
    .async_rst (async_rst),
    .bus       (bus)
  );

  always #5 clk_sync = ~clk_sync;

  typedef struct {
    string      tag;
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  // Output vector: {peer_rst_n, rst_done, busy, timeout_err}
  localparam logic [3:0] V_HOLD = 4'b0010;
  localparam logic [3:0] V_REL  = 4'b1010;
  localparam logic [3:0] V_RUN  = 4'b1100;
  localparam logic [3:0] V_ERR  = 4'b0001;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   edge_cnt = 0;
  int   base     = 0;

  always @(posedge clk_sync) edge_cnt <= edge_cnt + 1;

  function automatic logic [3:0] outs();
    return {bus.peer_rst_n, bus.rst_done, bus.busy, bus.timeout_err};
  endfunction

  task automatic push(input string tag, input int cyc, input logic [3:0] vec);
    exp_t e;
    e.tag = tag;
    e.cyc = cyc;
    e.vec = vec;
    sb.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [3:0] vec);
    exp_t e;
    push(tag, -1, vec);
    e = sb.pop_front();
    checks++;
    assert (outs() === e.vec) else begin
      errors++;
      $error("FAIL %s outputs got %b want %b", e.tag, outs(), e.vec);
    end
  endtask

  task automatic to_rel(input int n);
    while (edge_cnt - base < n) @(negedge clk_sync);
  endtask

  // Waits for the next output change (bounded), then scores it against the queue head.
  task automatic wait_change(input int budget);
    logic [3:0] prev, cur;
    exp_t       e;
    int         n;
    int         rel;
    prev = outs();
    cur  = prev;
    n    = 0;
    while (cur === prev && n < budget) begin
      @(negedge clk_sync);
      n++;
      cur = outs();
    end
    e   = sb.pop_front();
    rel = edge_cnt - base;
    checks++;
    assert (cur !== prev) else begin
      errors++;
      $error("FAIL %s no output change within %0d cycles, outputs %b want %b at edge %0d",
             e.tag, budget, cur, e.vec, e.cyc);
    end
    if (cur !== prev) begin
      checks++;
      assert (rel === e.cyc) else begin
        errors++;
        $error("FAIL %s edge got %0d want %0d", e.tag, rel, e.cyc);
      end
      checks++;
      assert (cur === e.vec) else begin
        errors++;
        $error("FAIL %s outputs got %b want %b", e.tag, cur, e.vec);
      end
    end
  endtask

  // From HOLD entry at base with peer_rdy low: release on edge 16, peer answers on edge 20.
  task automatic bring_up(input string tag);
    push({tag, " release"}, 16, V_REL);
    wait_change(40);
    to_rel(20);
    bus.peer_rdy = 1'b1;
    push({tag, " done"}, 23, V_RUN);
    wait_change(20);
  endtask

  initial begin
    bus.sw_rst_req = 1'b0;
    bus.peer_rdy   = 1'b0;

    #12;
    check_now("reset", V_HOLD);

    // T1: normal bring-up
    @(negedge clk_sync);
    async_rst = 1'b1;
    base      = edge_cnt;
    bring_up("T1");

    // T2: async reset away from any clock edge
    #3 async_rst = 1'b0;
    #1 check_now("T2 async", V_HOLD);

    // T3: peer stuck out of reset -> WAIT_LOW timeout, peer_rst_n never rises
    bus.peer_rdy = 1'b1;
    @(negedge clk_sync);
    @(negedge clk_sync);
    async_rst = 1'b1;
    base      = edge_cnt;
    push("T3 timeout", 1040, V_ERR);
    wait_change(1100);

    // T4: peer never comes out of reset -> RELEASE timeout
    async_rst    = 1'b0;
    bus.peer_rdy = 1'b0;
    @(negedge clk_sync);
    async_rst = 1'b1;
    base      = edge_cnt;
    push("T4 release", 16, V_REL);
    wait_change(40);
    push("T4 timeout", 1040, V_ERR);
    wait_change(1100);

    // T6: sw request clears the error; second pulse on hold edge 10 extends the hold
    bus.sw_rst_req = 1'b1;
    @(negedge clk_sync);
    bus.sw_rst_req = 1'b0;
    base           = edge_cnt;
    check_now("T6 clear", V_HOLD);
    to_rel(9);
    bus.sw_rst_req = 1'b1;
    @(negedge clk_sync);
    bus.sw_rst_req = 1'b0;
    push("T6 delayed release", 26, V_REL);
    wait_change(40);
    to_rel(30);
    bus.peer_rdy = 1'b1;
    push("T6 done", 33, V_RUN);
    wait_change(20);

    // Peer reset externally while running: sequencer stays in RUN
    bus.peer_rdy = 1'b0;
    repeat (8) @(negedge clk_sync);
    check_now("RUN peer drop", V_RUN);
    bus.peer_rdy = 1'b1;
    repeat (4) @(negedge clk_sync);

    // T5: sw request from RUN reruns the whole sequence with T1 timing
    bus.sw_rst_req = 1'b1;
    @(negedge clk_sync);
    bus.sw_rst_req = 1'b0;
    base           = edge_cnt;
    check_now("T5 enter", V_HOLD);
    bus.peer_rdy = 1'b0;
    bring_up("T5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
